// File: rtl/fwd_scoreboard_if.sv
// ID-stage <-> forwarding scoreboard bundle: issue info, source operands, completions, hazard outputs.
// Latency: pure signal grouping, no storage.
// Backpressure: stall is the only hold signal; the ID stage must not advance while it is high.
interface fwd_scoreboard_if #(
   parameter int REG_BITS = 5,
   parameter int NUM_SRC  = 2,
   parameter int LAT_W    = 3
);
   logic                        id_valid;
   logic                        id_wr_en;
   logic [REG_BITS-1:0]         id_rd;
   logic [LAT_W-1:0]            id_lat;
   logic                        id_var_lat;
   logic [NUM_SRC*REG_BITS-1:0] id_rs;
   logic [NUM_SRC-1:0]          id_use;
   logic                        flush;
   logic                        wb_done;
   logic [REG_BITS-1:0]         wb_done_rd;
   logic                        stall;
   logic [NUM_SRC-1:0]          fw_hit;
   logic [NUM_SRC*2-1:0]        fw_age;

   // ID stage / pipeline control side
   modport master (
      output id_valid, id_wr_en, id_rd, id_lat, id_var_lat, id_rs, id_use,
             flush, wb_done, wb_done_rd,
      input  stall, fw_hit, fw_age
   );

   // scoreboard side
   modport slave (
      input  id_valid, id_wr_en, id_rd, id_lat, id_var_lat, id_rs, id_use,
             flush, wb_done, wb_done_rd,
      output stall, fw_hit, fw_age
   );
endinterface

// File: rtl/fwd_scoreboard.sv
// Per-register scoreboard producing ID-stage stall and forward-select for fixed and variable latency producers.
// Latency: outputs are combinational from registered entry state plus current ID inputs; state updates each edge.
// Backpressure: stall holds ID and suppresses issue; optional FWD_SB_WB_BYPASS_EN lets a var result forward in its wb_done cycle.
module fwd_scoreboard #(
   parameter int REG_BITS    = 5,
   parameter int NUM_SRC     = 2,
   parameter int PIPE_DEPTH  = 3,
   parameter int LAT_W       = 3,
   parameter int FLUSH_DEPTH = 2
) (
   input logic              clk,
   input logic              rst,
   fwd_scoreboard_if.slave  sb
);
   localparam int         NUM_REGS = 1 << REG_BITS;
   localparam logic [1:0] AGE_LAST = 2'(PIPE_DEPTH - 1);

   // flattened view of the entry state for lookup by register index
   logic [NUM_REGS-1:0] busy_w;
   logic [NUM_REGS-1:0] var_w;
   logic [LAT_W-1:0]    rem_w [NUM_REGS];
   logic [1:0]          age_w [NUM_REGS];

   logic [NUM_SRC-1:0]   op_blocked;
   logic [NUM_SRC-1:0]   fw_hit_w;
   logic [NUM_SRC*2-1:0] fw_age_w;
   logic                 waw;
   logic                 stall_w;
   logic                 issue;

   // per-operand readiness and forward select
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [REG_BITS-1:0] rs;
      logic                op_vld;
      logic                e_ready;
      logic                e_bypass;

      assign rs      = sb.id_rs[i*REG_BITS +: REG_BITS];
      assign op_vld  = sb.id_use[i] && (rs != '0);
      assign e_ready = busy_w[rs] && !var_w[rs] && (rem_w[rs] == '0);
`ifdef FWD_SB_WB_BYPASS_EN
      // the var result is on the writeback bus right now, so take it from the WB stage
      assign e_bypass = busy_w[rs] && var_w[rs] && sb.wb_done && (sb.wb_done_rd == rs);
`else
      assign e_bypass = 1'b0;
`endif
      assign op_blocked[i]      = op_vld && busy_w[rs] && !e_ready && !e_bypass;
      assign fw_hit_w[i]        = op_vld && (e_ready || e_bypass);
      assign fw_age_w[i*2 +: 2] = !op_vld  ? 2'd0     :
                                  e_bypass ? AGE_LAST :
                                  e_ready  ? age_w[rs] : 2'd0;
   end

   // a second writer must wait for an outstanding var result so completions stay unambiguous
   assign waw     = sb.id_valid && sb.id_wr_en && busy_w[sb.id_rd] && var_w[sb.id_rd];
   assign stall_w = (|op_blocked) || waw;
   assign issue   = sb.id_valid && sb.id_wr_en && (sb.id_rd != '0) && !stall_w && !sb.flush;

   assign sb.stall  = stall_w;
   assign sb.fw_hit = fw_hit_w;
   assign sb.fw_age = fw_age_w;

   // one entry per architectural register; x0 is never loaded because issue excludes rd 0
   for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
      logic             busy_q;
      logic             var_q;
      logic [LAT_W-1:0] rem_q;
      logic [1:0]       age_q;
      logic             load;
      logic             clr;

      assign load = issue && (sb.id_rd == REG_BITS'(r));
      // fixed entries retire out of WB, var entries on their completion, young entries on flush
      assign clr  = (!var_q && (age_q == AGE_LAST))
                 || (var_q && sb.wb_done && (sb.wb_done_rd == REG_BITS'(r)))
                 || (sb.flush && (int'(age_q) < FLUSH_DEPTH));

      // load on issue (wins over any same-cycle clear), otherwise age or retire the entry
      always_ff @(posedge clk) begin
         if (rst) begin
            busy_q <= 1'b0;
            var_q  <= 1'b0;
            rem_q  <= '0;
            age_q  <= 2'd0;
         end else if (load) begin
            busy_q <= 1'b1;
            var_q  <= sb.id_var_lat;
            rem_q  <= sb.id_lat;
            age_q  <= 2'd0;
         end else if (busy_q) begin
            if (clr) begin
               busy_q <= 1'b0;
               var_q  <= 1'b0;
               rem_q  <= '0;
               age_q  <= 2'd0;
            end else begin
               rem_q <= (rem_q != '0) ? rem_q - LAT_W'(1) : rem_q;
               age_q <= (age_q != AGE_LAST) ? age_q + 2'd1 : age_q;
            end
         end
      end

      assign busy_w[r] = busy_q;
      assign var_w[r]  = var_q;
      assign rem_w[r]  = rem_q;
      assign age_w[r]  = age_q;
   end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: per-cycle vector table plus hand sequences for var latency and reset.
// Latency: checks combinational outputs each cycle on the falling edge.
// Backpressure: expected stall values are part of every vector.
module tb_fwd_scoreboard;
   logic clk;
   logic rst;

   fwd_scoreboard_if #(.REG_BITS(5), .NUM_SRC(2), .LAT_W(3)) sb_if ();

   fwd_scoreboard #(
      .REG_BITS(5), .NUM_SRC(2), .PIPE_DEPTH(3), .LAT_W(3), .FLUSH_DEPTH(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       vld;
      logic       wr;
      logic [4:0] rd;
      logic [2:0] lat;
      logic       var_lat;
      logic [4:0] rs0;
      logic [4:0] rs1;
      logic [1:0] use_m;
      logic       flush;
      logic       wbd;
      logic [4:0] wbd_rd;
      logic       e_stall;
      logic [1:0] e_hit;
      logic [3:0] e_age;
   } vec_t;

   vec_t vq[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic vec_t mk(
      input logic rst_i, input logic vld, input logic wr, input logic [4:0] rd,
      input logic [2:0] lat, input logic var_lat, input logic [4:0] rs0, input logic [4:0] rs1,
      input logic [1:0] use_m, input logic flush, input logic wbd, input logic [4:0] wbd_rd,
      input logic e_stall, input logic [1:0] e_hit, input logic [3:0] e_age);
      vec_t v;
      v.rst = rst_i; v.vld = vld; v.wr = wr; v.rd = rd; v.lat = lat; v.var_lat = var_lat;
      v.rs0 = rs0; v.rs1 = rs1; v.use_m = use_m; v.flush = flush; v.wbd = wbd; v.wbd_rd = wbd_rd;
      v.e_stall = e_stall; v.e_hit = e_hit; v.e_age = e_age;
      return v;
   endfunction

   task automatic check(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp_v);
      end
   endtask

   // drive one cycle of inputs, compare outputs mid-cycle, advance past the edge
   task automatic apply(input vec_t v, input string tag, input int idx, input bit chk);
      rst                = v.rst;
      sb_if.id_valid     = v.vld;
      sb_if.id_wr_en     = v.wr;
      sb_if.id_rd        = v.rd;
      sb_if.id_lat       = v.lat;
      sb_if.id_var_lat   = v.var_lat;
      sb_if.id_rs        = {v.rs1, v.rs0};
      sb_if.id_use       = v.use_m;
      sb_if.flush        = v.flush;
      sb_if.wb_done      = v.wbd;
      sb_if.wb_done_rd   = v.wbd_rd;
      @(negedge clk);
      if (chk) begin
         check({tag, ".stall"},  idx, {3'b0, sb_if.stall},  {3'b0, v.e_stall});
         check({tag, ".fw_hit"}, idx, {2'b0, sb_if.fw_hit}, {2'b0, v.e_hit});
         check({tag, ".fw_age"}, idx, sb_if.fw_age,         v.e_age);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t hv;
      rst = 1'b1;
      sb_if.id_valid = 1'b0; sb_if.id_wr_en = 1'b0; sb_if.id_rd = '0; sb_if.id_lat = '0;
      sb_if.id_var_lat = 1'b0; sb_if.id_rs = '0; sb_if.id_use = '0; sb_if.flush = 1'b0;
      sb_if.wb_done = 1'b0; sb_if.wb_done_rd = '0;
      repeat (2) @(posedge clk);
      #1;

      //         rst vld wr rd lat var rs0 rs1 use   fl wbd wrd  stl hit    age
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  5,  7, 2'b11, 0, 0, 0,  0, 2'b00, 4'h0)); // reset state
      // ALU forwarding, lat 0
      vq.push_back(mk(0, 1, 1, 5, 0, 0,  0,  0, 2'b00, 0, 0, 0,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  5,  0, 2'b01, 0, 0, 0,  0, 2'b01, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  5,  0, 2'b01, 0, 0, 0,  0, 2'b01, 4'h1));
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  5,  0, 2'b01, 0, 0, 0,  0, 2'b01, 4'h2));
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  5,  0, 2'b01, 0, 0, 0,  0, 2'b00, 4'h0));
      // load-use, lat 1, operand 1
      vq.push_back(mk(0, 1, 1, 7, 1, 0,  0,  0, 2'b00, 0, 0, 0,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  0,  7, 2'b10, 0, 0, 0,  1, 2'b00, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  0,  7, 2'b10, 0, 0, 0,  0, 2'b10, 4'h4));
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  0,  7, 2'b10, 0, 0, 0,  0, 2'b10, 4'h8));
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  0,  7, 2'b10, 0, 0, 0,  0, 2'b00, 4'h0));
      // lat 2 on both operands; stalled ID must not issue rd=10
      vq.push_back(mk(0, 1, 1, 8, 2, 0,  0,  0, 2'b00, 0, 0, 0,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 1, 1,10, 0, 0,  8,  8, 2'b11, 0, 0, 0,  1, 2'b00, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 10,  0, 2'b01, 0, 0, 0,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  8,  8, 2'b11, 0, 0, 0,  0, 2'b11, 4'hA));
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  8,  0, 2'b01, 0, 0, 0,  0, 2'b00, 4'h0));
      // id_use gating
      vq.push_back(mk(0, 1, 1,11, 0, 0,  0,  0, 2'b00, 0, 0, 0,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 11,  0, 2'b00, 0, 0, 0,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  0, 11, 2'b10, 0, 0, 0,  0, 2'b10, 4'h4));
      // x0: var write to rd 0 never busies, rs 0 never stalls
      vq.push_back(mk(0, 1, 1, 0, 0, 1,  0,  0, 2'b00, 0, 0, 0,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 1, 1, 0, 0, 0,  0,  0, 2'b01, 0, 0, 0,  0, 2'b00, 4'h0));
      // flush: var rd4 at age 2 survives, fixed rd3 at age 0 dies, rd6 issue suppressed
      vq.push_back(mk(0, 1, 1, 4, 0, 1,  0,  0, 2'b00, 0, 0, 0,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  0,  0, 2'b00, 0, 0, 0,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 1, 1, 3, 3, 0,  0,  0, 2'b00, 0, 0, 0,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 1, 1, 6, 0, 0,  0,  0, 2'b00, 1, 0, 0,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  3,  6, 2'b11, 0, 0, 0,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  4,  0, 2'b01, 0, 0, 0,  1, 2'b00, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  0,  0, 2'b00, 0, 1, 4,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  4,  0, 2'b01, 0, 0, 0,  0, 2'b00, 4'h0));
      // flush squashes a young var entry
      vq.push_back(mk(0, 1, 1,12, 0, 1,  0,  0, 2'b00, 0, 0, 0,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  0,  0, 2'b00, 1, 0, 0,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 12,  0, 2'b01, 0, 0, 0,  0, 2'b00, 4'h0));
      // wb_done on a fixed entry is ignored; re-issue on the retiring edge wins
      vq.push_back(mk(0, 1, 1,13, 0, 0,  0,  0, 2'b00, 0, 0, 0,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 13,  0, 2'b01, 0, 1,13,  0, 2'b01, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 13,  0, 2'b01, 0, 0, 0,  0, 2'b01, 4'h1));
      vq.push_back(mk(0, 1, 1,13, 0, 0, 13,  0, 2'b01, 0, 0, 0,  0, 2'b01, 4'h2));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 13,  0, 2'b01, 0, 0, 0,  0, 2'b01, 4'h0));
      // flush and wb_done together: both var entries go
      vq.push_back(mk(0, 1, 1,14, 0, 1,  0,  0, 2'b00, 0, 0, 0,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  0,  0, 2'b00, 0, 0, 0,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 1, 1,15, 0, 1,  0,  0, 2'b00, 0, 0, 0,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0,  0,  0, 2'b00, 1, 1,14,  0, 2'b00, 4'h0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 14, 15, 2'b11, 0, 0, 0,  0, 2'b00, 4'h0));

      for (int i = 0; i < vq.size(); i++) apply(vq[i], "tbl", i, 1'b1);

      // variable latency producer on x9, including WAW and an unrelated completion
      apply(mk(0, 1, 1, 9, 0, 1,  0, 0, 2'b00, 0, 0, 0,  0, 2'b00, 4'h0), "var", 0, 1'b1);
      apply(mk(0, 0, 0, 0, 0, 0,  9, 0, 2'b01, 0, 0, 0,  1, 2'b00, 4'h0), "var", 1, 1'b1);
      apply(mk(0, 1, 1, 9, 0, 0,  0, 0, 2'b00, 0, 0, 0,  1, 2'b00, 4'h0), "var_waw", 2, 1'b1);
      apply(mk(0, 0, 0, 0, 0, 0,  9, 0, 2'b01, 0, 1,10,  1, 2'b00, 4'h0), "var", 3, 1'b1);
`ifdef FWD_SB_WB_BYPASS_EN
      hv = mk(0, 0, 0, 0, 0, 0,  9, 0, 2'b01, 0, 1, 9,  0, 2'b01, 4'h2);
`else
      hv = mk(0, 0, 0, 0, 0, 0,  9, 0, 2'b01, 0, 1, 9,  1, 2'b00, 4'h0);
`endif
      apply(hv, "var_done", 4, 1'b1);
      apply(mk(0, 0, 0, 0, 0, 0,  9, 0, 2'b01, 0, 0, 0,  0, 2'b00, 4'h0), "var", 5, 1'b1);

      // reset mid-operation with var and fixed entries pending
      apply(mk(0, 1, 1, 5, 0, 1,  0, 0, 2'b00, 0, 0, 0,  0, 2'b00, 4'h0), "rst", 0, 1'b1);
      apply(mk(0, 1, 1, 6, 3, 0,  0, 0, 2'b00, 0, 0, 0,  0, 2'b00, 4'h0), "rst", 1, 1'b1);
      apply(mk(0, 1, 1, 7, 0, 0,  0, 0, 2'b00, 0, 0, 0,  0, 2'b00, 4'h0), "rst", 2, 1'b1);
      apply(mk(0, 0, 0, 0, 0, 0,  5, 7, 2'b11, 0, 0, 0,  1, 2'b10, 4'h0), "rst", 3, 1'b1);
      apply(mk(1, 0, 0, 0, 0, 0,  5, 6, 2'b11, 0, 0, 0,  0, 2'b00, 4'h0), "rst", 4, 1'b0);
      apply(mk(0, 0, 0, 0, 0, 0,  5, 6, 2'b11, 0, 0, 0,  0, 2'b00, 4'h0), "rst", 5, 1'b1);
      apply(mk(0, 1, 1, 5, 0, 0,  7, 0, 2'b01, 0, 0, 0,  0, 2'b00, 4'h0), "rst", 6, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised successor to the combinational forwarding unit. It tracks every in-flight register write in a per-register scoreboard, so producers of any latency can be handled: fixed multi-cycle producers (ALU, load, MUL) and variable-latency producers (DIV) that complete out of band. For each ID-stage source operand it produces a stall request and a forwarding select. It sits beside the ID stage and replaces per-stage rd comparators with state that ages along with the pipeline.

## Interface
Parameters:
- REG_BITS, 5, register index width; 2^REG_BITS scoreboard entries.
- NUM_SRC, 2, number of ID source operands checked per cycle.
- PIPE_DEPTH, 3, stages from EXE to WB inclusive; age 0 = EXE, PIPE_DEPTH-1 = WB.
- LAT_W, 3, width of the fixed-latency field.
- FLUSH_DEPTH, 2, entries with age < FLUSH_DEPTH are squashed by flush.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_wr_en  in  1  the ID instruction writes rd.
- id_rd  in  REG_BITS  destination register.
- id_lat  in  LAT_W  cycles after EXE entry before the result is forwardable (ALU 0, load 1).
- id_var_lat  in  1  variable-latency producer; id_lat is ignored.
- id_rs  in  NUM_SRC*REG_BITS  source registers, packed; operand i is at [i*REG_BITS +: REG_BITS].
- id_use  in  NUM_SRC  operand i is actually read.
- flush  in  1  squash young instructions.
- wb_done  in  1  a variable-latency result is written this cycle.
- wb_done_rd  in  REG_BITS  destination of that result.
- stall  out  1  hold ID; issue is suppressed.
- fw_hit  out  NUM_SRC  operand i must take the forwarded value.
- fw_age  out  NUM_SRC*2  stage index to forward from (0 = EXE, 1 = MEM, 2 = WB); 2 bits is sufficient for PIPE_DEPTH ≤ 4.

## Operation
- Each entry holds: busy, var, rem[LAT_W], age[2].
- Issue occurs when id_valid && id_wr_en && id_rd != 0 && !stall && !flush.
  - On issue the entry is loaded: busy=1, var=id_var_lat, rem=id_lat, age=0.
  - A newer issue to the same register overwrites the existing entry.
- Every cycle, each busy entry updates as follows:
  - rem decrements, saturating at 0.
  - age increments, saturating at PIPE_DEPTH-1.
- A fixed entry (var=0) clears on the clock edge where age == PIPE_DEPTH-1.
- A var entry:
  - Never counts as ready.
  - Clears when wb_done && wb_done_rd matches its register.
  - A wb_done for a register with no var entry is ignored.
- Per operand i, with e = entry[id_rs_i]:
  - Operand is valid when id_use[i] && id_rs_i != 0.
  - Not ready when e.busy && (e.var || e.rem != 0).
  - When busy and ready: fw_hit[i]=1 and fw_age_i=e.age.
  - When not busy: fw_hit[i]=0 and fw_age_i=0.
- stall is the OR of:
  - any valid operand that is not ready;
  - a WAW hazard: id_valid && id_wr_en && entry[id_rd] is busy with var=1.
- flush:
  - Clears every entry with age < FLUSH_DEPTH, including var entries.
  - Suppresses the issue in the same cycle.
- Simultaneous events:
  - An issue to a register whose entry clears in the same cycle: the issue wins.
  - Flush and wb_done in the same cycle: both clears apply.

## Timing
- Reset: all entries cleared. stall=0, fw_hit=0, fw_age=0 the cycle after rst is asserted.
- rst asserted mid-operation discards every pending entry, var entries included.
- Outputs are combinational from the registered scoreboard state and the current ID inputs. There is no output register.
- Producer issued at cycle t with id_lat=L:
  - A consumer in ID at cycle t+1+k stalls while k < L.
  - At k ≥ L the consumer gets fw_hit=1 with fw_age=min(k, PIPE_DEPTH-1).
- Entry lifetime for a fixed producer is PIPE_DEPTH cycles. The consumer then reads the register file.

## Configuration
- FWD_SB_WB_BYPASS_EN defined:
  - A var entry whose register matches wb_done_rd in the current cycle counts as ready.
  - Result: fw_hit=1, fw_age=PIPE_DEPTH-1, no stall that cycle.
- Undefined: the consumer stalls one extra cycle and then reads the register file.

## Test plan
- ALU forwarding: issue rd=5 with lat 0 at t; ID reads rs1=5 at t+1 → stall=0, fw_hit[0]=1, fw_age=0. At t+2 → fw_age=1. At t+4 → fw_hit=0.
- Load-use: issue rd=7 with lat 1 at t; ID reads rs2=7 at t+1 → stall=1. At t+2 → stall=0, fw_hit[1]=1, fw_age=1.
- Variable latency: var issue to rd=9; a consumer of x9 stalls until wb_done with wb_done_rd=9.
  - With the macro: stall drops in the wb_done cycle, fw_age=2.
  - Without the macro: stall drops one cycle later, fw_hit=0.
- WAW and x0:
  - A second write to a var-busy rd=9 → stall=1.
  - Writes to rd=0 never set busy.
  - rs=0 never stalls or forwards.
- Flush: issue rd=3 (age 0) and rd=4 (age 2), then assert flush → entry 3 cleared, entry 4 retained, and the same-cycle issue is suppressed.
- Reset mid-operation: three busy entries, then rst for one cycle → all outputs 0 and no stalls on the next reads.
